phase_capture_hls_deadlock_report_ctrl: RTL
===========================================

Name: phase_capture_hls_deadlock_report_ctrl

Overview:
Central sequencer for the per-process deadlock detect units of the phase capture HLS dataflow region. Watches every unit's deadlock flag and picks one flagged process as token origin (round-robin). Arms global detect mode, then traces the token around the dependence cycle. Either publishes a confirmed deadlock report (process mask plus origin) or aborts on timeout and clears tokens.

Parameters:
PROC_NUM, 4, number of dataflow processes / detect units.
TIMEOUT, 64, TRACE cycles allowed for the token to return to origin; legal range 2..65535.
CNT_W, 8, width of the saturating abort counter.

Ports:
clock  in  1  sole clock, rising edge.
reset  in  1  synchronous, active-high; all state and outputs return to reset values on the next rising edge.
dl_detect_vec  in  PROC_NUM  dl_detect_out of each detect unit, bit i = process i.
token_mon_vec  in  PROC_NUM  bit i = OR of process i's token_in_vec.
origin_vec  out  PROC_NUM  one-hot origin strobe to the units.
dl_detect_global  out  1  broadcast dl_detect_in to all units.
token_clear  out  1  broadcast token_clear pulse.
report_valid  out  1  confirmed-deadlock report valid.
report_ready  in  1  consumer accepts report.
report_origin  out  clog2(PROC_NUM), min 1  origin process index.
report_mask  out  PROC_NUM  processes in the deadlock cycle.
deadlock_flag  out  1  sticky: any deadlock confirmed since reset.
abort_count  out  CNT_W  saturating count of timed-out traces.
busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: every output 0. State IDLE. rr_ptr=0. seen=0. Timer=0.
- Round-robin pick: the lowest flagged index at or above rr_ptr, wrapping modulo PROC_NUM.
- IDLE:
  - If |dl_detect_vec, register origin_id using the round-robin pick.
  - Clear seen. Go to ARM.
  - All-zero dl_detect_vec: stay in IDLE.
- ARM (exactly 1 cycle):
  - origin_vec = onehot(origin_id).
  - dl_detect_global = 1.
  - timer = 0.
  - token_mon_vec is ignored in this cycle.
  - Go to TRACE.
- TRACE:
  - dl_detect_global = 1; origin_vec = 0.
  - Each cycle: seen |= token_mon_vec; timer++.
  - token_mon_vec[origin_id] = 1: go to REPORT. Latch report_mask = seen | token_mon_vec | onehot(origin_id).
  - Otherwise, timer == TIMEOUT-1: go to ABORT. Token return in the same cycle wins over timeout.
  - Deassertion of dl_detect_vec during TRACE is ignored.
- REPORT:
  - dl_detect_global = 1; report_valid = 1.
  - report_origin and report_mask are held stable until report_valid & report_ready.
  - On that handshake: set deadlock_flag; go to CLEAR.
  - report_ready high on REPORT entry gives a 1-cycle report.
- CLEAR (1 cycle):
  - token_clear = 1; dl_detect_global = 0.
  - rr_ptr = (origin_id+1) mod PROC_NUM.
  - Go to IDLE.
- ABORT (1 cycle):
  - token_clear = 1; dl_detect_global = 0.
  - abort_count++, saturating at 2^CNT_W-1.
  - rr_ptr = (origin_id+1) mod PROC_NUM.
  - Go to IDLE.
- Minimum IDLE-to-IDLE latency is 4 cycles: ARM, TRACE, REPORT with ready high, CLEAR.
- origin_vec and token_clear are always single-cycle pulses, never both high.
- Reset mid-operation: the next edge forces IDLE and zeroes outputs, including deadlock_flag and abort_count. No token_clear pulse is emitted.
- All outputs are registered (Moore); no combinational input-to-output paths.

Test Plan:
- PROC_NUM=4, dl_detect_vec=0100; token_mon_vec=1000 in TRACE cycle 2, then 0100 in cycle 4 -> origin_vec=0100 for 1 cycle; report_origin=2, report_mask=1100; deadlock_flag=1; rr_ptr=3.
- dl_detect_vec=1011 with rr_ptr=2 -> origin 3. After CLEAR, dl_detect_vec=0011 -> origin 0 (wrap).
- TIMEOUT=8, dl_detect_vec=0001, no token return -> ABORT entered exactly 8 TRACE cycles after ARM; token_clear 1 cycle; abort_count=1; deadlock_flag stays 0.
- Token return on the same cycle as timer==TIMEOUT-1 -> REPORT, not ABORT; abort_count unchanged.
- report_ready held low 5 cycles in REPORT -> report_valid, report_origin and report_mask stable for all 5 cycles; CLEAR on the cycle after ready rises.
- Force 300 aborts with CNT_W=8 -> abort_count saturates at 255. Assert reset during TRACE -> next cycle busy=0, all outputs 0, no token_clear pulse.

Source files
------------

// File: rtl/phase_capture_hls_deadlock_report_ctrl.sv
// Deadlock report sequencer for the phase capture HLS dataflow region.
// Picks a flagged process as token origin, traces the token, then reports or aborts.
module phase_capture_hls_deadlock_report_ctrl #(
  parameter int unsigned PROC_NUM = 4,
  parameter int unsigned TIMEOUT  = 64,
  parameter int unsigned CNT_W    = 8,
  localparam int unsigned OID_W   = (PROC_NUM > 1) ? $clog2(PROC_NUM) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [PROC_NUM-1:0] dl_detect_vec,
  input  logic [PROC_NUM-1:0] token_mon_vec,
  output logic [PROC_NUM-1:0] origin_vec,
  output logic                dl_detect_global,
  output logic                token_clear,
  output logic                report_valid,
  input  logic                report_ready,
  output logic [OID_W-1:0]    report_origin,
  output logic [PROC_NUM-1:0] report_mask,
  output logic                deadlock_flag,
  output logic [CNT_W-1:0]    abort_count,
  output logic                busy
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_TRACE  = 3'd2,
    S_REPORT = 3'd3,
    S_CLEAR  = 3'd4,
    S_ABORT  = 3'd5
  } state_e;

  state_e                state_q;
  logic [OID_W-1:0]      origin_id_q;
  logic [OID_W-1:0]      rr_ptr_q;
  logic [PROC_NUM-1:0]   seen_q;
  logic [TMR_W-1:0]      timer_q;

  logic [OID_W-1:0]      pick_c;
  logic                  found_c;
  int unsigned           idx_c;

  function automatic logic [PROC_NUM-1:0] onehot(input logic [OID_W-1:0] id);
    return PROC_NUM'(1) << id;
  endfunction

  function automatic logic [OID_W-1:0] next_ptr(input logic [OID_W-1:0] id);
    return (32'(id) == PROC_NUM - 1) ? '0 : OID_W'(32'(id) + 32'd1);
  endfunction

  // Round-robin pick: first flagged index at or after rr_ptr, wrapping.
  always_comb begin
    pick_c  = rr_ptr_q;
    found_c = 1'b0;
    idx_c   = 0;
    for (int unsigned off = 0; off < PROC_NUM; off++) begin
      idx_c = (32'(rr_ptr_q) + off) % PROC_NUM;
      if (!found_c && dl_detect_vec[OID_W'(idx_c)]) begin
        pick_c  = OID_W'(idx_c);
        found_c = 1'b1;
      end
    end
  end

  // Sequencer; every output is registered for the state being entered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= S_IDLE;
      origin_id_q      <= '0;
      rr_ptr_q         <= '0;
      seen_q           <= '0;
      timer_q          <= '0;
      origin_vec       <= '0;
      dl_detect_global <= 1'b0;
      token_clear      <= 1'b0;
      report_valid     <= 1'b0;
      report_origin    <= '0;
      report_mask      <= '0;
      deadlock_flag    <= 1'b0;
      abort_count      <= '0;
      busy             <= 1'b0;
    end else begin
      origin_vec  <= '0;
      token_clear <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (|dl_detect_vec) begin
            origin_id_q      <= pick_c;
            seen_q           <= '0;
            timer_q          <= '0;
            origin_vec       <= onehot(pick_c);
            dl_detect_global <= 1'b1;
            busy             <= 1'b1;
            state_q          <= S_ARM;
          end
        end
        S_ARM: begin
          timer_q <= '0;
          state_q <= S_TRACE;
        end
        S_TRACE: begin
          seen_q  <= seen_q | token_mon_vec;
          timer_q <= TMR_W'(timer_q + 1'b1);
          // Token return beats a simultaneous timeout.
          if (token_mon_vec[origin_id_q]) begin
            report_mask   <= seen_q | token_mon_vec | onehot(origin_id_q);
            report_origin <= origin_id_q;
            report_valid  <= 1'b1;
            state_q       <= S_REPORT;
          end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
            token_clear      <= 1'b1;
            dl_detect_global <= 1'b0;
            if (abort_count != {CNT_W{1'b1}}) begin
              abort_count <= CNT_W'(abort_count + 1'b1);
            end
            rr_ptr_q <= next_ptr(origin_id_q);
            state_q  <= S_ABORT;
          end
        end
        S_REPORT: begin
          if (report_ready) begin
            report_valid     <= 1'b0;
            deadlock_flag    <= 1'b1;
            token_clear      <= 1'b1;
            dl_detect_global <= 1'b0;
            rr_ptr_q         <= next_ptr(origin_id_q);
            state_q          <= S_CLEAR;
          end
        end
        S_CLEAR, S_ABORT: begin
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          dl_detect_global <= 1'b0;
          report_valid     <= 1'b0;
          busy             <= 1'b0;
          state_q          <= S_IDLE;
        end
      endcase
    end
  end

endmodule
